multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore FSM that sequences the RV32I multicycle datapath for lw, sw, R-type, I-type ALU, beq and jal.
//  It drives the PC, IR, register-file, memory and ALU mux controls.
//  A mem_ready handshake stretches the memory states.
//  Sits beside the datapath and replaces the single-cycle main decoder plus its PCSrc gating.
// PARAMETERS
//  CNT_W     32   width of the retired-instruction counter
// PORTS
//  clk         in   1      rising-edge clock, single clock domain
//  reset       in   1      synchronous, active-high
//  op          in   7      instr[6:0] from IR
//  funct3      in   3      instr[14:12]
//  funct7b5    in   1      instr[30]
//  zero        in   1      ALU zero flag
//  mem_ready   in   1      memory has completed the current read/write
//  PCWrite     out  1      PC register enable
//  AdrSrc      out  1      memory address: 0=PC, 1=Result
//  MemWrite    out  1      data memory write strobe
//  IRWrite     out  1      IR and OldPC enable
//  ResultSrc   out  2      00=ALUOut, 01=Data, 10=ALUResult
//  ALUSrcA     out  2      00=PC, 01=OldPC, 10=RD1
//  ALUSrcB     out  2      00=RD2, 01=ImmExt, 10=const 4
//  RegWrite    out  1      register-file write enable
//  immsrc      out  2      00=I, 01=S, 10=B, 11=J; combinational from op
//  ALUControl  out  3      000 add, 001 sub, 010 and, 011 or, 101 slt
//  illegal_op  out  1      sticky; set on an unsupported opcode
//  instret     out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Reset
//   - While reset=1, at the next edge: state<=FETCH, illegal_op<=0, instret<=0.
//   - While reset=1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
//   - Reset mid-instruction aborts it. No partial write occurs after reset is seen.
//  State table (outputs not listed are 0 / 00; ALUOp is internal)
//   FETCH   : AdrSrc=0, A=00, B=10, ALUOp=00, ResultSrc=10
//             IRWrite=mem_ready, PCUpdate=mem_ready
//             -> DECODE if mem_ready, else stay in FETCH
//   DECODE  : A=01, B=01, ALUOp=00 (branch target into ALUOut)
//             lw,sw -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI
//             1100011 -> BEQ; 1101111 -> JAL; any other op -> ILLEGAL
//   MEMADR  : A=10, B=01, ALUOp=00
//             -> MEMREAD if op=0000011, else MEMWRITE
//   MEMREAD : AdrSrc=1, ResultSrc=00
//             -> MEMWB on mem_ready, else stay in MEMREAD
//   MEMWB   : ResultSrc=01, RegWrite=1 -> FETCH
//   MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 (held until mem_ready)
//             -> FETCH on mem_ready
//   EXECR   : A=10, B=00, ALUOp=10 -> ALUWB
//   EXECI   : A=10, B=01, ALUOp=10 -> ALUWB
//   ALUWB   : ResultSrc=00, RegWrite=1 -> FETCH
//   JAL     : A=01, B=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB
//   BEQ     : A=10, B=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH
//   ILLEGAL : all strobes 0, illegal_op<=1; stays in ILLEGAL until reset
//  Branch and PC
//   - PCWrite = PCUpdate | (Branch & zero).
//  ALU decode (combinational)
//   - ALUOp 00 -> add; ALUOp 01 -> sub.
//   - ALUOp 10, by funct3:
//       000 -> sub if {op[5],funct7b5}==11, else add
//       010 -> slt; 110 -> or; 111 -> and; others -> add
//  Retired count
//   - instret increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
//   - Wraps modulo 2^CNT_W.
//  mem_ready
//   - Ignored in all states except FETCH, MEMREAD and MEMWRITE.
// STRUCTURE
//  - Shared package riscv_pkg:
//      opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
//      state encoding (4-bit localparams S_FETCH..S_ILLEGAL)
//      mux-select and ALUControl encodings
//  - One sub-module alu_dec (ALUOp, funct3, op5, funct7b5 -> ALUControl), instantiated here.
//  - State register plus registered illegal_op and instret. All other outputs decoded from state.
// TESTING
//  1. reset=1 for 2 cycles, then low, mem_ready=1
//     -> cycle 1: FETCH with IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10; instret=0.
//  2. lw (op=0000011), mem_ready=1
//     -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB (RegWrite=1, ResultSrc=01), FETCH;
//        5 cycles; instret +1.
//  3. sw with mem_ready low for 3 cycles in MEMWRITE
//     -> MemWrite=1 held for 4 cycles, then FETCH; no RegWrite at any point.
//  4. beq with zero=1, then zero=0
//     -> BEQ cycle PCWrite=1 / PCWrite=0; ALUControl=001; immsrc=10.
//  5. R-type sub (funct3=000, funct7b5=1) -> EXECR ALUControl=001.
//     I-type addi with funct7b5=1 -> add (000).
//     jal -> JAL PCWrite=1, then ALUWB RegWrite=1.
//  6. op=1111111 -> ILLEGAL after DECODE; illegal_op=1; no strobes for 10 cycles.
//     Then reset -> illegal_op=0 and state=FETCH.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcodes, state encoding and mux/ALU encodings for the RV32I multicycle controller
package riscv_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_4     = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_SW:   imm_sel = IMM_S;
      OP_BEQ:  imm_sel = IMM_B;
      OP_JAL:  imm_sel = IMM_J;
      default: imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_dec.sv
// rtl/alu_dec.sv - ALU control decode from ALUOp, funct3, op[5] and funct7[5]
module alu_dec
  import riscv_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_op5,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // only R-type (op[5]=1) can encode sub; addi ignores instr[30]
          3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore control FSM sequencing the RV32I multicycle datapath
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegWrite,
  output logic [1:0]       immsrc,
  output logic [2:0]       ALUControl,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instret
);

  state_t           r_state;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instret;

  logic [1:0] w_alu_op;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_retire;

  always_comb begin
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_irwrite   = 1'b0;
    w_memwrite  = 1'b0;
    w_regwrite  = 1'b0;
    w_alu_op    = ALUOP_ADD;
    AdrSrc      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RD2;
    case (r_state)
      S_FETCH: begin
        ALUSrcB     = SRCB_4;
        ResultSrc   = RES_ALURES;
        w_irwrite   = mem_ready;
        w_pc_update = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        w_regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA  = SRCA_RD1;
        w_alu_op = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA  = SRCA_RD1;
        ALUSrcB  = SRCB_IMM;
        w_alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: w_regwrite = 1'b1;
      S_JAL: begin
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_4;
        w_pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = SRCA_RD1;
        w_alu_op = ALUOP_SUB;
        w_branch = 1'b1;
      end
      default: ;
    endcase
  end

  // strobes are masked during reset so an aborted instruction can't commit
  assign PCWrite  = ~reset & (w_pc_update | (w_branch & zero));
  assign IRWrite  = ~reset & w_irwrite;
  assign MemWrite = ~reset & w_memwrite;
  assign RegWrite = ~reset & w_regwrite;

  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BEQ) ||
                    ((r_state == S_MEMWRITE) && mem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
      if (r_state == S_ILLEGAL) r_illegal <= 1'b1;
      case (r_state)
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_R:         r_state <= S_EXECR;
            OP_I:         r_state <= S_EXECI;
            OP_BEQ:       r_state <= S_BEQ;
            OP_JAL:       r_state <= S_JAL;
            default:      r_state <= S_ILLEGAL;
          endcase
        end
        S_MEMADR:   r_state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
        S_EXECR:    r_state <= S_ALUWB;
        S_EXECI:    r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_JAL:      r_state <= S_ALUWB;
        S_BEQ:      r_state <= S_FETCH;
        S_ILLEGAL:  r_state <= S_ILLEGAL;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  assign illegal_op = r_illegal;
  assign instret    = r_instret;
  assign immsrc     = imm_sel(op);

  alu_dec u_alu_dec (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_op5         (op[5]),
    .i_funct7b5    (funct7b5),
    .o_alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl with an instruction-sequence model
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        mem_ready;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, immsrc;
  logic [2:0]  ALUControl;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite), .immsrc(immsrc),
    .ALUControl(ALUControl), .illegal_op(illegal_op), .instret(instret)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // model: an instruction is a list of phases; position 0/1 are fetch/decode
  typedef enum {K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL, K_ILL} kind_e;
  typedef enum {P_F, P_D, P_A, P_RD, P_RWB, P_WR, P_X, P_WB, P_J, P_B, P_ILL} phase_e;

  int          m_pos;
  kind_e       m_kind;
  logic        m_ill;
  logic [31:0] m_cnt;

  function automatic kind_e kind_of(input logic [6:0] o);
    case (o)
      7'b0000011: return K_LW;
      7'b0100011: return K_SW;
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b1100011: return K_BEQ;
      7'b1101111: return K_JAL;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic phase_e phase_at(input int pos, input kind_e k);
    if (pos == 0) return P_F;
    if (pos == 1) return P_D;
    case (k)
      K_LW:      return (pos == 2) ? P_A : (pos == 3) ? P_RD : P_RWB;
      K_SW:      return (pos == 2) ? P_A : P_WR;
      K_R, K_I:  return (pos == 2) ? P_X : P_WB;
      K_BEQ:     return P_B;
      K_JAL:     return (pos == 2) ? P_J : P_WB;
      default:   return P_ILL;
    endcase
  endfunction

  function automatic int last_pos(input kind_e k);
    case (k)
      K_LW:    return 4;
      K_BEQ:   return 2;
      K_ILL:   return 1000;
      default: return 3;
    endcase
  endfunction

  function automatic logic [48:0] model_expect();
    logic pcw, adr, mw, irw, rw;
    logic [1:0] rs, a, b, imm;
    logic [2:0] alu;
    phase_e ph;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
    rs = 2'b00; a = 2'b00; b = 2'b00; alu = 3'b000;
    ph = phase_at(m_pos, m_kind);
    case (ph)
      P_F:   begin b = 2'b10; rs = 2'b10; irw = mem_ready; pcw = mem_ready; end
      P_D:   begin a = 2'b01; b = 2'b01; end
      P_A:   begin a = 2'b10; b = 2'b01; end
      P_RD:  adr = 1;
      P_RWB: begin rs = 2'b01; rw = 1; end
      P_WR:  begin adr = 1; mw = 1; end
      P_X: begin
        a = 2'b10;
        b = (m_kind == K_R) ? 2'b00 : 2'b01;
        case (funct3)
          3'b000:  alu = (m_kind == K_R && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu = 3'b101;
          3'b110:  alu = 3'b011;
          3'b111:  alu = 3'b010;
          default: alu = 3'b000;
        endcase
      end
      P_WB:  rw = 1;
      P_J:   begin a = 2'b01; b = 2'b10; pcw = 1; end
      P_B:   begin a = 2'b10; alu = 3'b001; pcw = zero; end
      default: ;
    endcase
    if (reset) begin pcw = 0; irw = 0; mw = 0; rw = 0; end
    case (op)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu, m_ill, m_cnt};
  endfunction

  task automatic model_reset();
    m_pos = 0; m_kind = K_ILL; m_ill = 0; m_cnt = 0;
  endtask

  task automatic model_update();
    phase_e ph;
    if (reset) begin
      model_reset();
    end else begin
      ph = phase_at(m_pos, m_kind);
      if (ph == P_ILL) m_ill = 1;
      else if ((ph == P_F || ph == P_RD || ph == P_WR) && !mem_ready) ;
      else if (m_pos >= 2 && m_pos == last_pos(m_kind)) begin
        m_pos = 0;
        m_cnt = m_cnt + 1;
      end else begin
        if (m_pos == 1) m_kind = kind_of(op);
        m_pos++;
      end
    end
  endtask

  task automatic tick();
    logic [48:0] act;
    @(negedge clk);
    act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
           immsrc, ALUControl, illegal_op, instret};
    check("model", 64'(act), 64'(model_expect()));
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [2:0] alu;
    logic [1:0] imm;
    int         len;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [6:0] pick_op();
    case ($urandom_range(0, 19))
      0:       return ($urandom_range(0, 1) == 0) ? 7'h7F : 7'h37;
      1, 2, 3: return 7'b0000011;
      4, 5, 6: return 7'b0100011;
      7, 8, 9, 10: return 7'b0110011;
      11, 12, 13: return 7'b0010011;
      14, 15, 16: return 7'b1100011;
      default: return 7'b1101111;
    endcase
  endfunction

  initial begin
    int cycles;
    int mw_cnt;
    logic rw_seen;
    logic [31:0] start_cnt;

    tbl[0]  = '{7'b0000011, 3'b010, 1'b0, 3'b000, 2'b00, 5};
    tbl[1]  = '{7'b0100011, 3'b010, 1'b0, 3'b000, 2'b01, 4};
    tbl[2]  = '{7'b0110011, 3'b000, 1'b1, 3'b001, 2'b00, 4};
    tbl[3]  = '{7'b0110011, 3'b000, 1'b0, 3'b000, 2'b00, 4};
    tbl[4]  = '{7'b0110011, 3'b010, 1'b0, 3'b101, 2'b00, 4};
    tbl[5]  = '{7'b0110011, 3'b110, 1'b0, 3'b011, 2'b00, 4};
    tbl[6]  = '{7'b0110011, 3'b111, 1'b0, 3'b010, 2'b00, 4};
    tbl[7]  = '{7'b0110011, 3'b100, 1'b1, 3'b000, 2'b00, 4};
    tbl[8]  = '{7'b0010011, 3'b000, 1'b1, 3'b000, 2'b00, 4};
    tbl[9]  = '{7'b0010011, 3'b010, 1'b0, 3'b101, 2'b00, 4};
    tbl[10] = '{7'b1100011, 3'b000, 1'b0, 3'b001, 2'b10, 3};
    tbl[11] = '{7'b1101111, 3'b000, 1'b0, 3'b000, 2'b11, 4};

    reset = 1; mem_ready = 1; op = 7'b0000011; funct3 = 0; funct7b5 = 0; zero = 0;
    @(posedge clk);
    model_reset();
    #1;
    check("rst_irwrite", 64'(IRWrite), 64'(0));
    check("rst_pcwrite", 64'(PCWrite), 64'(0));
    check("rst_instret", 64'(instret), 64'(0));
    check("rst_illegal", 64'(illegal_op), 64'(0));
    tick();
    reset = 0;
    #1;
    check("fetch_irwrite", 64'(IRWrite), 64'(1));
    check("fetch_pcwrite", 64'(PCWrite), 64'(1));
    check("fetch_srcb", 64'(ALUSrcB), 64'(2'b10));
    check("fetch_ressrc", 64'(ResultSrc), 64'(2'b10));
    check("fetch_instret", 64'(instret), 64'(0));

    for (int i = 0; i < 12; i++) begin
      op = tbl[i].op; funct3 = tbl[i].f3; funct7b5 = tbl[i].f7; zero = 0; mem_ready = 1;
      start_cnt = m_cnt;
      tick(); tick();
      check($sformatf("tbl%0d_alu", i), 64'(ALUControl), 64'(tbl[i].alu));
      check($sformatf("tbl%0d_imm", i), 64'(immsrc), 64'(tbl[i].imm));
      cycles = 2;
      while (IRWrite !== 1'b1 && cycles < 12) begin
        tick();
        cycles++;
      end
      check($sformatf("tbl%0d_len", i), 64'(cycles), 64'(tbl[i].len));
      check($sformatf("tbl%0d_ret", i), 64'(instret), 64'(start_cnt + 1));
    end

    op = 7'b0100011; mem_ready = 1;
    tick(); tick(); tick();
    mw_cnt = 0; rw_seen = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      if (MemWrite === 1'b1) mw_cnt++;
      if (RegWrite !== 1'b0) rw_seen = 1;
      tick();
    end
    check("sw_memwrite_cycles", 64'(mw_cnt), 64'(4));
    check("sw_no_regwrite", 64'(rw_seen), 64'(0));
    check("sw_back_fetch", 64'(IRWrite), 64'(1));

    for (int z = 1; z >= 0; z--) begin
      op = 7'b1100011; zero = 1'(z); mem_ready = 1;
      tick(); tick();
      check($sformatf("beq_z%0d_pcwrite", z), 64'(PCWrite), 64'(z));
      check("beq_alu", 64'(ALUControl), 64'(3'b001));
      check("beq_imm", 64'(immsrc), 64'(2'b10));
      tick();
    end
    zero = 0;

    op = 7'b1101111;
    tick(); tick();
    check("jal_pcwrite", 64'(PCWrite), 64'(1));
    tick();
    check("jal_wb_regwrite", 64'(RegWrite), 64'(1));
    tick();

    op = 7'b0100011; mem_ready = 1;
    tick(); tick(); tick();
    mem_ready = 0;
    tick();
    reset = 1;
    #1;
    check("abort_memwrite", 64'(MemWrite), 64'(0));
    tick();
    reset = 0; mem_ready = 1;
    #1;
    check("abort_fetch", 64'(IRWrite), 64'(1));
    check("abort_instret", 64'(instret), 64'(0));

    op = 7'h7F;
    tick(); tick();
    rw_seen = 0;
    for (int i = 0; i < 10; i++) begin
      mem_ready = 1'($urandom_range(0, 1)); zero = 1;
      #1;
      if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000) rw_seen = 1;
      tick();
    end
    check("illegal_no_strobes", 64'(rw_seen), 64'(0));
    check("illegal_sticky", 64'(illegal_op), 64'(1));
    reset = 1;
    tick();
    reset = 0; mem_ready = 1; zero = 0; op = 7'b0110011;
    #1;
    check("illegal_cleared", 64'(illegal_op), 64'(0));
    check("illegal_to_fetch", 64'(IRWrite), 64'(1));

    for (int c = 0; c < 3000; c++) begin
      mem_ready = ($urandom_range(0, 9) < 6);
      zero = 1'($urandom_range(0, 1));
      if (m_pos == 0) begin
        op = pick_op();
        funct3 = 3'($urandom_range(0, 7));
        funct7b5 = 1'($urandom_range(0, 1));
      end
      reset = (m_ill && $urandom_range(0, 3) == 0) || ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
